// File: rtl/au_dispatch_if.sv
// Host and engine bus of the arithmetic-unit dispatcher: command handshake,
// result/status back to the host, and the per-engine control/result fan.
interface au_dispatch_if #(
    parameter int N_ENG = 3,
    parameter int DW    = 16,
    parameter int DIN_W = 32,
    parameter int CW    = 8
);
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [3:0]               cmd_op;
    logic [N_ENG-1:0][CW-1:0] cmd_ctrl;
    logic [DIN_W-1:0]         data_in;
    logic [15:0]              add;
    logic [DW-1:0]            rand_in;

    logic [DW-1:0]            data_out;
    logic                     end_op;
    logic                     done;
    logic                     busy;
    logic                     err;
    logic                     load_seed;

    logic [N_ENG-1:0][CW-1:0] eng_ctrl;
    logic [N_ENG-1:0]         eng_rst_n;
    logic [DIN_W-1:0]         eng_din;
    logic [15:0]              eng_add;
    logic [N_ENG-1:0]         eng_end_op;
    logic [N_ENG-1:0][DW-1:0] eng_dout;

    modport slave (
        input  cmd_valid, cmd_op, cmd_ctrl, data_in, add, rand_in,
        input  eng_end_op, eng_dout,
        output cmd_ready, data_out, end_op, done, busy, err, load_seed,
        output eng_ctrl, eng_rst_n, eng_din, eng_add
    );

    modport master (
        output cmd_valid, cmd_op, cmd_ctrl, data_in, add, rand_in,
        output eng_end_op, eng_dout,
        input  cmd_ready, data_out, end_op, done, busy, err, load_seed,
        input  eng_ctrl, eng_rst_n, eng_din, eng_add
    );
endinterface

// File: rtl/au_dispatch.sv
// Command dispatcher for the ML-KEM arithmetic engines: decodes opcodes, runs a
// START/wait/done handshake with timeout, and muxes the selected engine result.

// One link of the priority chain: claims the channel if its control byte is
// nonzero and no lower-index channel has claimed it yet.
module au_dispatch_lane #(
    parameter int DW = 16,
    parameter int CW = 8
) (
    input  logic [CW-1:0] ctrl,
    input  logic          taken_i,
    input  logic [DW-1:0] dout,
    input  logic          end_op,
    output logic          sel,
    output logic          taken_o,
    output logic [DW-1:0] dout_m,
    output logic          end_m
);
    logic nz;

    assign nz      = |ctrl;
    assign sel     = nz & ~taken_i;
    assign taken_o = taken_i | nz;
    assign dout_m  = sel ? dout : '0;
    assign end_m   = sel & end_op;
endmodule

module au_dispatch #(
    parameter int N_ENG = 3,
    parameter int DW    = 16,
    parameter int DIN_W = 32,
    parameter int CW    = 8,
    parameter int TMO_W = 16
) (
    input logic          clk,
    input logic          rst,
    au_dispatch_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, ERR} state_t;

    localparam logic [3:0] OP_RESET  = 4'h0;
    localparam logic [3:0] OP_LOAD   = 4'h1;
    localparam logic [3:0] OP_SEED   = 4'h2;
    localparam logic [3:0] OP_START  = 4'h3;
    localparam logic [3:0] OP_READ   = 4'h4;
    localparam logic [3:0] OP_RAND_A = 4'h6;
    localparam logic [3:0] OP_RAND_B = 4'h7;
    localparam logic [3:0] OP_RAND8  = 4'h8;

    state_t                   state_q, state_d;
    logic [N_ENG-1:0][CW-1:0] ctrl_q, ctrl_d;
    logic [3:0]               op_q, op_d;
    logic [DW-1:0]            rand_q, rand_d;
    logic [TMO_W-1:0]         tmo_q, tmo_d;
    logic                     err_q, err_d;
    logic                     done_q, done_d;
    logic [N_ENG-1:0]         eng_rst_n_q, eng_rst_n_d;

    logic [N_ENG:0]           taken;
    logic [N_ENG-1:0]         sel_oh;
    logic [N_ENG-1:0][DW-1:0] dout_m;
    logic [N_ENG-1:0]         end_m;
    logic [DW-1:0]            sel_dout;
    logic                     sel_any;
    logic                     sel_end;
    logic                     accept;
    logic [DIN_W-1:0]         din_fwd;

    // Priority chain over registered control bytes; channel 0 wins.
    assign taken[0] = 1'b0;
    for (genvar g = 0; g < N_ENG; g++) begin : g_lane
        au_dispatch_lane #(.DW(DW), .CW(CW)) u_lane (
            .ctrl    (ctrl_q[g]),
            .taken_i (taken[g]),
            .dout    (bus.eng_dout[g]),
            .end_op  (bus.eng_end_op[g]),
            .sel     (sel_oh[g]),
            .taken_o (taken[g+1]),
            .dout_m  (dout_m[g]),
            .end_m   (end_m[g])
        );
    end

    always_comb begin
        sel_dout = '0;
        for (int i = 0; i < N_ENG; i++) sel_dout = sel_dout | dout_m[i];
    end

    assign sel_any = taken[N_ENG];
    assign sel_end = |end_m;

    assign bus.cmd_ready = (state_q == IDLE) | (bus.cmd_op == OP_RESET);
    assign accept        = bus.cmd_valid & bus.cmd_ready;

    always_comb begin
        state_d     = state_q;
        ctrl_d      = ctrl_q;
        op_d        = op_q;
        rand_d      = rand_q;
        tmo_d       = tmo_q;
        err_d       = err_q;
        done_d      = 1'b0;
        eng_rst_n_d = '1;
        if (accept && bus.cmd_op == OP_RESET) begin
            // Accepted from any state; aborts RUN without a done pulse.
            state_d     = IDLE;
            ctrl_d      = '0;
            op_d        = '0;
            rand_d      = '0;
            tmo_d       = '0;
            err_d       = 1'b0;
            eng_rst_n_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        case (bus.cmd_op)
                            OP_LOAD, OP_SEED, OP_READ: begin
                                ctrl_d = bus.cmd_ctrl;
                                op_d   = bus.cmd_op;
                            end
                            OP_START: begin
                                ctrl_d = bus.cmd_ctrl;
                                tmo_d  = '0;
                                if (|bus.cmd_ctrl) state_d = RUN;
                                else               done_d  = 1'b1;
                            end
                            OP_RAND_A, OP_RAND_B: begin
                                rand_d = bus.rand_in;
                                ctrl_d = '0;
                            end
                            OP_RAND8: begin
                                rand_d      = '0;
                                rand_d[7:0] = bus.rand_in[7:0];
                                ctrl_d      = '0;
                            end
                            default: op_d = bus.cmd_op;  // END and NOP
                        endcase
                    end
                end
                RUN: begin
                    // Completion is checked first so it beats a same-edge timeout.
                    if (sel_end) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (&tmo_q) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            ctrl_q      <= '0;
            op_q        <= '0;
            rand_q      <= '0;
            tmo_q       <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            eng_rst_n_q <= '0;
        end else begin
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            op_q        <= op_d;
            rand_q      <= rand_d;
            tmo_q       <= tmo_d;
            err_q       <= err_d;
            done_q      <= done_d;
            eng_rst_n_q <= eng_rst_n_d;
        end
    end

    assign din_fwd       = bus.data_in;
    assign bus.eng_din   = din_fwd;
    assign bus.eng_add   = bus.add;
    assign bus.eng_ctrl  = ctrl_q;
    assign bus.eng_rst_n = eng_rst_n_q;
    assign bus.load_seed = (op_q == OP_SEED);
    assign bus.data_out  = sel_any ? sel_dout : rand_q;
    assign bus.end_op    = (state_q != RUN);
    assign bus.busy      = (state_q == RUN);
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_au_dispatch.sv
// Directed bench for au_dispatch: reset, run/done, priority, timeout, rand and abort.
module tb_au_dispatch;
    localparam int N_ENG = 3;
    localparam int DW    = 16;
    localparam int DIN_W = 32;
    localparam int CW    = 8;
    localparam int TMO_W = 4;

    localparam logic [3:0] RESET  = 4'h0;
    localparam logic [3:0] LOAD   = 4'h1;
    localparam logic [3:0] SEED   = 4'h2;
    localparam logic [3:0] START  = 4'h3;
    localparam logic [3:0] NOP    = 4'h5;
    localparam logic [3:0] RAND16 = 4'h6;
    localparam logic [3:0] RAND8  = 4'h8;

    logic clk;
    logic rst;
    int   nvec;
    int   nmis;

    au_dispatch_if #(.N_ENG(N_ENG), .DW(DW), .DIN_W(DIN_W), .CW(CW)) bus ();

    au_dispatch #(.N_ENG(N_ENG), .DW(DW), .DIN_W(DIN_W), .CW(CW), .TMO_W(TMO_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] op, input logic [23:0] ctrl);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_ctrl  = ctrl;
        tick();
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = NOP;
    endtask

    initial begin
        nvec = 0;
        nmis = 0;
        rst  = 1'b0;
        bus.cmd_valid  = 1'b0;
        bus.cmd_op     = NOP;
        bus.cmd_ctrl   = '0;
        bus.data_in    = 32'hCAFE0001;
        bus.add        = 16'h0040;
        bus.rand_in    = '0;
        bus.eng_end_op = '0;
        bus.eng_dout   = {16'h2222, 16'hBEEF, 16'h1111};
        tick();
        tick();

        chk("rst_end_op", 32'(bus.end_op), 1);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_err", 32'(bus.err), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_dout", 32'(bus.data_out), 0);
        chk("rst_eng_rst", 32'(bus.eng_rst_n), 0);
        rst = 1'b1;
        tick();
        chk("rel_eng_rst", 32'(bus.eng_rst_n), 7);
        chk("idle_ready", 32'(bus.cmd_ready), 1);
        chk("fwd_din", bus.eng_din, 32'hCAFE0001);
        chk("fwd_add", 32'(bus.eng_add), 32'h0040);

        // Engine 1 finishes ten cycles into RUN.
        send(START, 24'h000500);
        chk("run1_busy0", 32'(bus.busy), 1);
        chk("run1_endop", 32'(bus.end_op), 0);
        chk("run1_ctrl", 32'(bus.eng_ctrl), 32'h000500);
        chk("run1_dout", 32'(bus.data_out), 32'hBEEF);
        chk("run1_ready", 32'(bus.cmd_ready), 0);
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("run1_busy", 32'(bus.busy), 1);
            chk("run1_nodone", 32'(bus.done), 0);
        end
        bus.eng_end_op = 3'b010;
        tick();
        chk("run1_done", 32'(bus.done), 1);
        chk("run1_idle", 32'(bus.busy), 0);
        chk("run1_endop1", 32'(bus.end_op), 1);
        chk("run1_res", 32'(bus.data_out), 32'hBEEF);
        bus.eng_end_op = '0;
        tick();
        chk("run1_pulse", 32'(bus.done), 0);

        // Bytes 0 and 2 set: channel 0 owns the operation.
        send(START, 24'h030001);
        chk("pri_dout", 32'(bus.data_out), 32'h1111);
        bus.eng_end_op = 3'b100;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("pri_e2_ign", 32'(bus.busy), 1);
        end
        bus.eng_end_op = 3'b001;
        tick();
        chk("pri_done", 32'(bus.done), 1);
        chk("pri_idle", 32'(bus.busy), 0);
        bus.eng_end_op = '0;
        tick();

        send(SEED, 24'h000009);
        chk("seed_flag", 32'(bus.load_seed), 1);
        chk("seed_ctrl", 32'(bus.eng_ctrl), 32'h000009);
        chk("seed_busy", 32'(bus.busy), 0);
        send(LOAD, 24'h000000);
        chk("load_flag", 32'(bus.load_seed), 0);

        bus.rand_in = 16'h1234;
        send(RAND8, 24'h000000);
        chk("rand8", 32'(bus.data_out), 32'h0034);
        bus.rand_in = 16'hA5C3;
        send(RAND16, 24'h000000);
        chk("rand16", 32'(bus.data_out), 32'hA5C3);

        send(START, 24'h000000);
        chk("zstart_done", 32'(bus.done), 1);
        chk("zstart_busy", 32'(bus.busy), 0);
        chk("zstart_dout", 32'(bus.data_out), 32'hA5C3);
        tick();
        chk("zstart_pulse", 32'(bus.done), 0);

        // Completion on the very edge where the timeout would fire.
        send(START, 24'h000001);
        for (int i = 0; i < 15; i++) tick();
        bus.eng_end_op = 3'b001;
        tick();
        chk("edge_done", 32'(bus.done), 1);
        chk("edge_noerr", 32'(bus.err), 0);
        bus.eng_end_op = '0;
        tick();

        // Timeout after 16 RUN cycles.
        send(START, 24'h000001);
        for (int i = 0; i < 15; i++) tick();
        chk("tmo_busy15", 32'(bus.busy), 1);
        chk("tmo_noerr15", 32'(bus.err), 0);
        tick();
        chk("tmo_err", 32'(bus.err), 1);
        chk("tmo_busy", 32'(bus.busy), 0);
        chk("tmo_endop", 32'(bus.end_op), 1);
        chk("tmo_nodone", 32'(bus.done), 0);
        bus.cmd_op    = START;
        bus.cmd_valid = 1'b1;
        #1;
        chk("err_refuse", 32'(bus.cmd_ready), 0);
        tick();
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = NOP;
        chk("err_hold", 32'(bus.err), 1);
        chk("err_busy", 32'(bus.busy), 0);
        chk("err_dout", 32'(bus.data_out), 32'h1111);
        bus.cmd_op = RESET;
        #1;
        chk("err_rst_rdy", 32'(bus.cmd_ready), 1);
        send(RESET, 24'h000000);
        chk("clr_err", 32'(bus.err), 0);
        chk("clr_eng_rst", 32'(bus.eng_rst_n), 0);
        chk("clr_dout", 32'(bus.data_out), 0);
        tick();
        chk("clr_eng_rel", 32'(bus.eng_rst_n), 7);

        // Abort three cycles into RUN.
        send(START, 24'h070000);
        tick();
        tick();
        chk("abt_busy", 32'(bus.busy), 1);
        bus.cmd_op = RESET;
        #1;
        chk("abt_rdy", 32'(bus.cmd_ready), 1);
        send(RESET, 24'h000000);
        chk("abt_idle", 32'(bus.busy), 0);
        chk("abt_endop", 32'(bus.end_op), 1);
        chk("abt_nodone", 32'(bus.done), 0);
        chk("abt_ctrl", 32'(bus.eng_ctrl), 0);
        chk("abt_eng_rst", 32'(bus.eng_rst_n), 0);
        tick();
        chk("abt_nodone2", 32'(bus.done), 0);
        chk("abt_eng_rel", 32'(bus.eng_rst_n), 7);

        // Asynchronous reset mid-RUN.
        send(START, 24'h000500);
        tick();
        chk("arst_busy", 32'(bus.busy), 1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_busy0", 32'(bus.busy), 0);
        chk("arst_endop", 32'(bus.end_op), 1);
        chk("arst_eng_rst", 32'(bus.eng_rst_n), 0);
        chk("arst_ctrl", 32'(bus.eng_ctrl), 0);
        chk("arst_dout", 32'(bus.data_out), 0);
        rst = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule

// File: doc/au_dispatch.md
# au_dispatch

Parametrised dispatcher between the ML-KEM control bus and N arithmetic engines (NTT/ACC, SHA3/XOF/PRF, byte encode/decode, and others). It decodes a command opcode and per-engine control bytes, and runs a handshaked START/wait/done sequence with a per-operation timeout. It muxes the selected engine's result and holds a 16/8-bit random register. It replaces the flat combinational select of the current arithmetic-unit core and adds back-pressure, abort, and error reporting.

## Interface
- N_ENG, 3, number of engine channels (1..8); channel 0 has the highest priority
- DW, 16, engine result width
- DIN_W, 32, data_in width, passed through to engines
- CW, 8, control byte width per engine
- TMO_W, 16, timeout counter width; timeout fires at count 2^TMO_W-1
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when valid&ready
- cmd_op  in  4  opcode: 0 RESET, 1 LOAD, 2 LOAD_SEED, 3 START, 4 READ, 6/7 RAND16, 8 RAND8, F END; others NOP
- cmd_ctrl  in  N_ENG*CW  control bytes; byte i belongs to engine i
- data_in  in  DIN_W  operand data, forwarded to all engines unregistered
- add  in  16  address, forwarded to all engines unregistered
- rand_in  in  DW  free-running random source
- eng_ctrl  out  N_ENG*CW  registered control bytes to engines
- eng_rst_n  out  N_ENG  engine resets, active-low
- load_seed  out  1  high while the latched opcode is LOAD_SEED
- eng_end_op  in  N_ENG  engine completion levels
- eng_dout  in  N_ENG*DW  engine results
- data_out  out  DW  selected engine result, or rand_q
- end_op  out  1  level, high when not RUN
- done  out  1  one-cycle completion pulse
- busy  out  1  state==RUN
- err  out  1  sticky timeout flag

## Operation
- FSM states: IDLE, RUN, ERR.
- Reset (rst=0):
  - state=IDLE, ctrl_q=0, op_q=0, rand_q=0, tmo=0, err=0.
  - done=0, eng_rst_n=all 0, busy=0, end_op=1, data_out=0.
- cmd_ready = (state==IDLE) | (cmd_op==RESET). In ERR, only RESET is accepted.
- Accepted commands:
  - RESET: ctrl_q, op_q, rand_q, tmo and err cleared; eng_rst_n all low for exactly the next cycle; state→IDLE. Aborts RUN.
  - LOAD / LOAD_SEED / READ: ctrl_q←cmd_ctrl, op_q←cmd_op; state stays IDLE.
  - START: ctrl_q←cmd_ctrl, tmo←0.
    - If any control byte is nonzero: state→RUN.
    - Otherwise: done pulses next cycle and state stays IDLE.
  - RAND16: rand_q←rand_in. RAND8: rand_q←{8'h00, rand_in[7:0]}. ctrl_q←0 for both.
  - END / NOP: op_q←cmd_op; no other effect.
- Engine select:
  - sel = lowest index i with ctrl_q byte i nonzero.
  - sel_any = OR over all control bytes.
  - data_out = sel_any ? eng_dout[sel] : rand_q (combinational from registers/inputs).
- RUN behaviour, each cycle:
  - If eng_end_op[sel]=1: state→IDLE, done=1 the next cycle.
  - Else if tmo==all-ones: state→ERR, err←1.
  - Else tmo←tmo+1.
- ERR: end_op=1, busy=0. err holds until RESET. data_out continues to follow sel.
- eng_ctrl = ctrl_q, held constant through RUN. The engines see control before RUN begins: the cycle ctrl_q updates.

## Timing
- START accepted at edge t: ctrl_q/state valid after t; eng_end_op first sampled at edge t+1.
- Minimum START→done latency is 2 cycles: end_op already high at t+1.
- Timeout: ERR entered on the edge where tmo==2^TMO_W-1 and end_op is still low, i.e. 2^TMO_W cycles after entering RUN.
- Simultaneous end_op and timeout on the same edge: completion wins; no error.
- RESET accepted during RUN: no done pulse; eng_rst_n low for the one cycle after acceptance.
- done never asserts in the same cycle as cmd_ready for the command that caused it.
- rst asserted mid-RUN: all outputs return to reset values immediately, asynchronously.

## Test plan
- Reset values: hold rst=0 then release → end_op=1, busy=0, err=0, data_out=0, eng_rst_n=3'b000 then 3'b111 after release.
- START with cmd_ctrl byte1=8'h05, others 0; eng_end_op[1] rises 10 cycles later, eng_dout[1]=16'hBEEF → busy for 10 cycles, done single pulse, data_out=16'hBEEF.
- Priority: START with bytes0 and 2 nonzero → sel=0; only eng_end_op[0] completes the operation, and eng_end_op[2] alone does not.
- Timeout with TMO_W=4 and eng_end_op never rising → err=1 after 16 RUN cycles; START is refused (cmd_ready=0); RESET clears err and pulses eng_rst_n low one cycle.
- RAND8 with rand_in=16'h1234 → data_out=16'h0034; RAND16 with rand_in=16'hA5C3 → 16'hA5C3; START with all-zero ctrl → done pulse, no RUN.
- Abort: RESET issued 3 cycles into RUN → state IDLE, no done, ctrl_q=0, end_op=1.
